// File: rtl/main_control_fsm_if.sv
// Handshake and control bundle between the main control FSM (master) and the
// instruction/data memory plus register-file/ALU datapath (slave).
interface main_control_fsm_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic [1:0]  ALUOp;
    logic [3:0]  opcode;
    logic [1:0]  Funct;
    logic [7:0]  pc_step;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        mem_timeout;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr, mem_ready, zero,
        output ALUOp, opcode, Funct, pc_step, mem_read, mem_write, ir_write,
               pc_write, pc_src, reg_write, reg_dst, alu_src, mem_to_reg,
               mem_timeout, illegal, state
    );

    modport slave (
        output instr, mem_ready, zero,
        input  ALUOp, opcode, Funct, pc_step, mem_read, mem_write, ir_write,
               pc_write, pc_src, reg_write, reg_dst, alu_src, mem_to_reg,
               mem_timeout, illegal, state
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the 16-bit CPU (fetch/decode/exec/mem/wb).
// Define ILLEGAL_TRAP_EN to halt on undefined opcodes instead of running them as NOPs.
module main_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int PC_STEP    = 2
) (
    input  logic               clk,
    input  logic               reset,
    main_control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt;
    logic [3:0]  ir_op, opcode_q;
    logic [1:0]  ir_fn, funct_q;
    logic        timeout_q, illegal_q;
    logic        timeout_evt, wait_hit, entering_wait;
    logic [1:0]  alu_op;
    logic        mem_read, mem_write, ir_write, pc_write, pc_src;
    logic        reg_write, reg_dst, alu_src, mem_to_reg;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001);
    endfunction

    function automatic logic is_ifmt(input logic [3:0] op);
        return (op == 4'b0010) || (op == 4'b1001) || (op == 4'b1010) || (op == 4'b1011);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return is_rtype(op) || is_ifmt(op) || (op == 4'b0100) || (op == 4'b0101) ||
               (op == 4'b0110);
    endfunction

    // Ready in the limit cycle still wins because the FSM checks mem_ready first.
    assign wait_hit      = (int'(wait_cnt) + 1) >= WAIT_LIMIT;
    assign entering_wait = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));

    always_comb begin
        state_d     = state_q;
        timeout_evt = 1'b0;
        alu_op      = 2'b00;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_hit) begin
                    timeout_evt = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_rtype(opcode_q)) begin
                    alu_op  = 2'b10;
                    reg_dst = 1'b1;
                    state_d = S_WB;
                end else if (is_ifmt(opcode_q)) begin
                    alu_op  = 2'b11;
                    alu_src = 1'b1;
                    state_d = S_WB;
                end else if ((opcode_q == 4'b0100) || (opcode_q == 4'b0101)) begin
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else if (opcode_q == 4'b0110) begin
                    alu_op   = 2'b01;
                    pc_write = bus.zero;
                    pc_src   = bus.zero;
                    state_d  = S_FETCH;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                mem_read  = (opcode_q == 4'b0100);
                mem_write = (opcode_q == 4'b0101);
                if (bus.mem_ready) begin
                    state_d = (opcode_q == 4'b0100) ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    timeout_evt = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode_q == 4'b0100);
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_cnt  <= 8'd0;
            ir_op     <= 4'd0;
            ir_fn     <= 2'd0;
            opcode_q  <= 4'd0;
            funct_q   <= 2'd0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_write) begin
                ir_op <= bus.instr[15:12];
                ir_fn <= bus.instr[1:0];
            end
            if (state_q == S_DECODE) begin
                opcode_q <= ir_op;
                funct_q  <= ir_fn;
            end
            if (timeout_evt) timeout_q <= 1'b1;
            if (entering_wait) begin
                wait_cnt <= 8'd0;
            end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
`ifdef ILLEGAL_TRAP_EN
            if ((state_q == S_DECODE) && !is_legal(ir_op)) illegal_q <= 1'b1;
`else
            if (state_q == S_DECODE) begin
                illegal_q <= !is_legal(ir_op);
            end else if (state_d == S_FETCH) begin
                illegal_q <= 1'b0;
            end
`endif
        end
    end

    // Enables are forced low while reset is held so a pending write drops at once.
    assign bus.mem_read    = mem_read   & ~reset;
    assign bus.mem_write   = mem_write  & ~reset;
    assign bus.ir_write    = ir_write   & ~reset;
    assign bus.pc_write    = pc_write   & ~reset;
    assign bus.pc_src      = pc_src     & ~reset;
    assign bus.reg_write   = reg_write  & ~reset;
    assign bus.reg_dst     = reg_dst    & ~reset;
    assign bus.alu_src     = alu_src    & ~reset;
    assign bus.mem_to_reg  = mem_to_reg & ~reset;
    assign bus.ALUOp       = alu_op;
    assign bus.opcode      = opcode_q;
    assign bus.Funct       = funct_q;
    assign bus.pc_step     = 8'(PC_STEP);
    assign bus.mem_timeout = timeout_q;
    assign bus.illegal     = illegal_q | ((state_q == S_DECODE) && !is_legal(ir_op));
    assign bus.state       = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized bench for main_control_fsm against a per-instruction trace model.
`timescale 1ns/1ps
module tb_main_control_fsm;
    localparam int WL  = 4;
    localparam int PCS = 2;
    localparam logic [8:0] E_MR  = 9'b100000000;
    localparam logic [8:0] E_MW  = 9'b010000000;
    localparam logic [8:0] E_IRW = 9'b001000000;
    localparam logic [8:0] E_PCW = 9'b000100000;
    localparam logic [8:0] E_PCS = 9'b000010000;
    localparam logic [8:0] E_RW  = 9'b000001000;
    localparam logic [8:0] E_RD  = 9'b000000100;
    localparam logic [8:0] E_AS  = 9'b000000010;
    localparam logic [8:0] E_MTR = 9'b000000001;

    logic clk = 1'b0;
    logic reset;
    main_control_fsm_if bus();

    main_control_fsm #(.WAIT_LIMIT(WL), .PC_STEP(PCS)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        z;
        logic [15:0] ins;
        logic [21:0] exp;
    } cyc_t;

    cyc_t        plan[$];
    logic [21:0] obs_q[$];
    int          vectors = 0;
    int          fails   = 0;
    logic [3:0]  m_op;
    logic [1:0]  m_fn;
    logic        m_to, m_ill;

    function automatic logic [21:0] obs_word();
        return {bus.state, bus.ALUOp, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_to_reg,
                bus.mem_timeout, bus.illegal, bus.opcode, bus.Funct};
    endfunction

    function automatic logic [21:0] ew(input int st, input logic [1:0] aop,
                                       input logic [8:0] en, input logic ill);
        return {3'(st), aop, en, m_to, ill, m_op, m_fn};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic z, input logic [15:0] ins, input logic [21:0] e);
        cyc_t c;
        c.rdy = rdy; c.z = z; c.ins = ins; c.exp = e;
        plan.push_back(c);
    endtask

    task automatic model_reset();
        m_op = 4'd0; m_fn = 2'd0; m_to = 1'b0; m_ill = 1'b0;
    endtask

    // Expected trace of one instruction; a wait of WL or more means memory never answers.
    task automatic plan_instr(input logic [15:0] ins, input int fw, input int mw, input logic z);
        logic [3:0] op;
        logic r, im, lw, sw, beq;
        op  = ins[15:12];
        r   = (op == 4'h0) || (op == 4'h1);
        im  = (op == 4'h2) || (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
        lw  = (op == 4'h4);
        sw  = (op == 4'h5);
        beq = (op == 4'h6);
        for (int k = 0; k < WL; k++) begin
            if (k == fw) begin
                push(1'b1, rb(), ins, ew(0, 2'b00, E_MR | E_IRW | E_PCW, 1'b0));
                break;
            end
            push(1'b0, rb(), 16'($urandom), ew(0, 2'b00, E_MR, 1'b0));
        end
        if (fw >= WL) begin
            m_to = 1'b1;
            return;
        end
        push(rb(), rb(), 16'($urandom), ew(1, 2'b00, 9'd0, !(r || im || lw || sw || beq)));
        m_op = op;
        m_fn = ins[1:0];
        if (r) begin
            push(rb(), rb(), 16'($urandom), ew(2, 2'b10, E_RD, 1'b0));
        end else if (im) begin
            push(rb(), rb(), 16'($urandom), ew(2, 2'b11, E_AS, 1'b0));
        end else if (lw || sw) begin
            push(rb(), rb(), 16'($urandom), ew(2, 2'b00, E_AS, 1'b0));
        end else if (beq) begin
            push(rb(), z, 16'($urandom), ew(2, 2'b01, z ? (E_PCW | E_PCS) : 9'd0, 1'b0));
            return;
        end else begin
            push(rb(), rb(), 16'($urandom), ew(2, 2'b00, 9'd0, 1'b1));
`ifdef ILLEGAL_TRAP_EN
            m_ill = 1'b1;
`endif
            return;
        end
        if (lw || sw) begin
            for (int k = 0; k < WL; k++) begin
                if (k == mw) begin
                    push(1'b1, rb(), 16'($urandom), ew(3, 2'b00, lw ? E_MR : E_MW, 1'b0));
                    break;
                end
                push(1'b0, rb(), 16'($urandom), ew(3, 2'b00, lw ? E_MR : E_MW, 1'b0));
            end
            if (mw >= WL) begin
                m_to = 1'b1;
                return;
            end
            if (sw) return;
        end
        push(rb(), rb(), 16'($urandom), ew(4, 2'b00, E_RW | (lw ? E_MTR : 9'd0), 1'b0));
    endtask

    task automatic plan_halt(input int n);
        for (int k = 0; k < n; k++) push(rb(), rb(), 16'($urandom), ew(5, 2'b00, 9'd0, m_ill));
    endtask

    task automatic apply_plan();
        obs_q.delete();
        foreach (plan[i]) begin
            bus.mem_ready = plan[i].rdy;
            bus.zero      = plan[i].z;
            bus.instr     = plan[i].ins;
            @(negedge clk);
            obs_q.push_back(obs_word());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hard_reset();
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.mem_ready = 1'b1;
        bus.instr     = 16'($urandom);
        @(negedge clk);
        vectors++;
        if (obs_word() !== ew(0, 2'b00, 9'd0, 1'b0)) begin
            fails++;
            $display("FAIL reset_values: got %h, want %h", obs_word(), ew(0, 2'b00, 9'd0, 1'b0));
        end
        vectors++;
        if (bus.pc_step !== 8'(PCS)) begin
            fails++;
            $display("FAIL pc_step: got %0d, want %0d", bus.pc_step, PCS);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_word() !== ew(0, 2'b00, E_MR, 1'b0)) begin
            fails++;
            $display("FAIL reset_release_fetch: got %h, want %h", obs_word(), ew(0, 2'b00, E_MR, 1'b0));
        end
        hard_reset();
    endtask

    task automatic test_rtype();
        plan.delete();
        plan_instr(16'h0123, 0, 0, 1'b0);
        plan_instr({4'h1, 12'($urandom)}, $urandom_range(0, WL - 1), 0, rb());
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL rtype cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_lw_delay();
        plan.delete();
        plan_instr({4'h4, 12'($urandom)}, $urandom_range(0, WL - 1), 3, 1'b0);
        plan_instr({4'h4, 12'($urandom)}, 0, 0, 1'b1);
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL lw_delay cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_beq();
        plan.delete();
        plan_instr({4'h6, 12'($urandom)}, 0, 0, 1'b1);
        plan_instr({4'h6, 12'($urandom)}, 1, 0, 1'b0);
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL beq cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] legal_ops [9];
        logic [3:0] bad_ops   [7];
        logic [3:0] op;
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hB};
        bad_ops   = '{4'h3, 4'h7, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF};
        plan.delete();
        for (int n = 0; n < 30; n++) begin
            op = legal_ops[$urandom_range(0, 8)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 4) == 0) op = bad_ops[$urandom_range(0, 6)];
`endif
            plan_instr({op, 12'($urandom)}, $urandom_range(0, WL - 1),
                       $urandom_range(0, WL - 1), rb());
        end
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL back_to_back cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_timeout();
        plan.delete();
        plan_instr({4'h0, 12'($urandom)}, WL, 0, 1'b0);
        plan_halt(5);
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL fetch_timeout cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
        hard_reset();
        plan.delete();
        plan_instr({4'h9, 12'($urandom)}, WL - 1, 0, 1'b0);
        plan_instr({4'h4, 12'($urandom)}, 0, WL, 1'b0);
        plan_halt(3);
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL limit_and_mem_timeout cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
        hard_reset();
    endtask

    task automatic test_illegal();
        plan.delete();
        plan_instr({4'hF, 12'($urandom)}, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        plan_halt(4);
`else
        plan_instr({4'h0, 12'($urandom)}, 0, 0, 1'b0);
`endif
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL illegal cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
        hard_reset();
        plan.delete();
        plan_instr({4'hB, 12'($urandom)}, 0, 0, 1'b0);
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL illegal_after_reset cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        plan.delete();
        plan_instr({4'h5, 12'($urandom)}, 0, 1, 1'b0);
        void'(plan.pop_back());
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL sw_to_mem cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
        bus.mem_ready = 1'b0;
        #2;
        vectors++;
        if (bus.mem_write !== 1'b1) begin
            fails++;
            $display("FAIL sw_mem_write_before_reset: got %b, want 1", bus.mem_write);
        end
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (obs_word() !== ew(0, 2'b00, 9'd0, 1'b0)) begin
            fails++;
            $display("FAIL async_reset_mid_sw: got %h, want %h", obs_word(), ew(0, 2'b00, 9'd0, 1'b0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        plan.delete();
        plan_instr({4'h2, 12'($urandom)}, 1, 0, 1'b0);
        apply_plan();
        foreach (plan[i]) begin
            vectors++;
            if (obs_q[i] !== plan[i].exp) begin
                fails++;
                $display("FAIL after_mid_reset cyc %0d: got %h, want %h", i, obs_q[i], plan[i].exp);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.instr     = 16'd0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_lw_delay();
        test_beq();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_mid_sw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, want finish");
        $fatal(1);
    end
endmodule
